reservation_station: RTL
========================

# reservation_station

Out-of-order issue buffer for one functional-unit class. It accepts decoded instructions from dispatch, but only those whose station code matches its own; it holds them until both source operands are available; it snoops the common data bus (CDB) for missing operands; and it issues the oldest ready entry to its functional unit over a valid/ready handshake. One instance exists per station code: ALU 00, load/store 01, branch 10, LUI/AUIPC/JAL 11.

## Interface
- DEPTH, 4: number of entries, ≥2.
- DATA_W, 32: operand width.
- TAG_W, 5: ROB tag width.
- OP_W, 4: functional-unit opcode width.
- STATION_ID, 2'b00: station code this instance accepts.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- disp_valid  in  1  dispatch offers an instruction.
- disp_station  in  2  station code of the offered instruction.
- disp_ready  out  1  high when at least one entry is free.
- disp_op  in  OP_W  functional-unit opcode.
- disp_rob_tag  in  TAG_W  destination ROB tag.
- disp_src1_val / disp_src2_val  in  DATA_W  operand values.
- disp_src1_rdy / disp_src2_rdy  in  1  operand value is valid.
- disp_src1_tag / disp_src2_tag  in  TAG_W  producer tag, used when the operand is not ready.
- disp_use_imm  in  1  replace src2 with the immediate.
- disp_imm  in  DATA_W  extended immediate.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- iss_valid  out  1  an entry is ready to issue.
- iss_ready  in  1  functional unit accepts the issue.
- iss_op  out  OP_W  opcode of the issued entry.
- iss_a  out  DATA_W  first operand of the issued entry.
- iss_b  out  DATA_W  second operand of the issued entry.
- iss_rob_tag  out  TAG_W  ROB tag of the issued entry.
- flush  in  1  discard all entries.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage is a compacting queue. Entry 0 is the oldest; occupied entries are always contiguous from index 0.
- Accept condition: disp_valid && disp_ready && disp_station==STATION_ID.
- An accepted instruction is written at index count, or at count-1 when an issue fires in the same cycle.
- When disp_use_imm=1, src2 is set to disp_imm with ready=1, and disp_src2_* is ignored.
- Dispatch-time CDB bypass: if a dispatched operand has rdy=0 and its tag equals cdb_tag while cdb_valid=1, the entry captures cdb_data and stores the operand as ready.
- Wakeup: each cycle, every occupied entry whose operand is not ready and whose tag matches a valid CDB broadcast captures cdb_data and sets that operand ready.
- Select: iss_valid is high when any occupied entry has both operands ready. The payload comes from the lowest such index.
- Payload is combinational from registered state. An operand woken in cycle N cannot issue before cycle N+1.
- The payload may change while iss_ready=0, because an older entry can become ready. The consumer samples only on the handshake cycle.
- Issue: on iss_valid && iss_ready, the selected entry is removed at the edge, and every entry above it shifts down by one.
- disp_ready = (count != DEPTH). It does not credit a same-cycle issue.
- Flush has priority over dispatch, wakeup and issue. After the edge, count=0.
- Reset values: every entry invalid, count=0, iss_valid=0, disp_ready=1, iss_op/iss_a/iss_b/iss_rob_tag=0.

## Timing
- Minimum latency: an instruction accepted at edge N with both operands ready shows iss_valid=1 after edge N and issues at edge N+1 if iss_ready=1.
- A CDB broadcast at edge N sets operand ready after edge N, so the earliest issue is at edge N+1.
- Dispatch, wakeup and issue in the same cycle operate on the pre-shift indices; writes are remapped consistently after compaction.
- Full: disp_ready=0 even when an issue fires that cycle. Dispatch resumes the cycle after.
- Empty: iss_valid=0 and the payload is 0.
- Reset asserted mid-operation clears state immediately (asynchronous), and no issue occurs.

## Structure
- Package rs_pkg holds:
  - the rs_entry_t struct: valid, op, rob_tag, src1/src2 {val, rdy, tag};
  - the station codes STATION_ALU=2'b00, STATION_LS=2'b01, STATION_BR=2'b10, STATION_UPC=2'b11.
- Sub-module rs_pick_oldest: a DEPTH-bit ready vector in; found flag and index out (lowest-index priority encoder).

## Test plan
- Reset, then dispatch op=3, tag=7, src1=5, src2=9, both ready → iss_valid rises the next cycle with iss_a=5, iss_b=9, iss_rob_tag=7; count returns to 0 after the handshake.
- Dispatch with src1 not ready (tag=4), then CDB {tag=4, data=0xAA} two cycles later → iss_valid=0 until the cycle after the broadcast; then iss_a=0xAA.
- Dispatch three entries, only entry 1 ready, iss_ready=1 → entry 1 issues; the former entry 2 moves to index 1 and count=2.
- Fill DEPTH=4 with unready entries → disp_ready=0. A fifth dispatch is not accepted. Waking entry 0 then issuing it → disp_ready=1 the next cycle.
- disp_station=01 presented to STATION_ID=00 → count unchanged; disp_use_imm=1 with imm=0x10 → iss_b=0x10 regardless of src2.
- Flush while count=3 with a same-cycle dispatch and a same-cycle issue → count=0 and iss_valid=0 after the edge; asserting reset_n=0 mid-run clears every output immediately.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation station.
//   - Default operand, tag and opcode widths. The entry struct is built
//     from these, so any instance must use the same widths.
//   - Station codes for the four functional-unit classes.
//   - rs_entry_t: one buffered instruction with its two source operands.
//   - rs_wake: applies a CDB broadcast to an entry.
package rs_pkg;

    localparam int RS_DATA_W = 32;
    localparam int RS_TAG_W  = 5;
    localparam int RS_OP_W   = 4;

    localparam logic [1:0] STATION_ALU = 2'b00;
    localparam logic [1:0] STATION_LS  = 2'b01;
    localparam logic [1:0] STATION_BR  = 2'b10;
    localparam logic [1:0] STATION_UPC = 2'b11;

    typedef struct packed {
        logic [RS_DATA_W-1:0] val;
        logic                 rdy;
        logic [RS_TAG_W-1:0]  tag;
    } rs_src_t;

    typedef struct packed {
        logic                 valid;
        logic [RS_OP_W-1:0]   op;
        logic [RS_TAG_W-1:0]  rob_tag;
        rs_src_t              src1;
        rs_src_t              src2;
    } rs_entry_t;

    // A waiting operand whose producer tag matches the broadcast takes the data.
    function automatic rs_src_t rs_snoop(input rs_src_t s, input logic cv,
                                         input logic [RS_TAG_W-1:0] ct,
                                         input logic [RS_DATA_W-1:0] cd);
        rs_src_t r;
        r = s;
        if (!s.rdy && cv && (s.tag == ct)) begin
            r.val = cd;
            r.rdy = 1'b1;
        end
        return r;
    endfunction

    function automatic rs_entry_t rs_wake(input rs_entry_t e, input logic cv,
                                          input logic [RS_TAG_W-1:0] ct,
                                          input logic [RS_DATA_W-1:0] cd);
        rs_entry_t r;
        r = e;
        if (e.valid) begin
            r.src1 = rs_snoop(e.src1, cv, ct, cd);
            r.src2 = rs_snoop(e.src2, cv, ct, cd);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_pick_oldest.sv
// Lowest-index priority encoder used to select the oldest ready entry.
//   req   : DEPTH-bit request vector, bit 0 is the oldest entry
//   found : at least one request bit is set
//   idx   : index of the lowest set bit (0 when none)
module rs_pick_oldest #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         req,
    output logic                     found,
    output logic [$clog2(DEPTH)-1:0] idx
);

    localparam int IW = $clog2(DEPTH);

    // Scanning from the top lets the lowest set bit win.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer for one functional-unit class.
//   dispatch in : disp_valid/disp_station/disp_* operands, disp_ready out
//   cdb in      : cdb_valid/cdb_tag/cdb_data wake up waiting operands
//   issue out   : iss_valid/iss_op/iss_a/iss_b/iss_rob_tag, iss_ready in
//   flush in    : drops every entry; count out : occupied entries
// Entries form a compacting queue: index 0 is the oldest, occupied entries
// are contiguous from 0, and an issue shifts everything above it down.
module reservation_station
    import rs_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter int         DATA_W     = RS_DATA_W,
    parameter int         TAG_W      = RS_TAG_W,
    parameter int         OP_W       = RS_OP_W,
    parameter logic [1:0] STATION_ID = STATION_ALU
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       disp_valid,
    input  logic [1:0]                 disp_station,
    output logic                       disp_ready,
    input  logic [OP_W-1:0]            disp_op,
    input  logic [TAG_W-1:0]           disp_rob_tag,
    input  logic [DATA_W-1:0]          disp_src1_val,
    input  logic [DATA_W-1:0]          disp_src2_val,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic                       disp_use_imm,
    input  logic [DATA_W-1:0]          disp_imm,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OP_W-1:0]            iss_op,
    output logic [DATA_W-1:0]          iss_a,
    output logic [DATA_W-1:0]          iss_b,
    output logic [TAG_W-1:0]           iss_rob_tag,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    rs_entry_t        entries_q [DEPTH];
    rs_entry_t        entries_d [DEPTH];
    rs_entry_t        woken     [DEPTH];
    rs_entry_t        shifted   [DEPTH];
    logic [CW-1:0]    count_q, count_d, wr_idx;
    logic [DEPTH-1:0] ready_vec;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             accept, fire;
    rs_entry_t        disp_raw, disp_entry;

    // Per entry: readiness from registered state, CDB wakeup, then the
    // compaction shift applied to the already-woken values.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign ready_vec[gi] = entries_q[gi].valid && entries_q[gi].src1.rdy
                                   && entries_q[gi].src2.rdy;
            assign woken[gi] = rs_wake(entries_q[gi], cdb_valid, cdb_tag, cdb_data);
            if (gi < DEPTH - 1) begin : g_mid
                assign shifted[gi] = (fire && (IW'(gi) >= sel_idx)) ? woken[gi+1]
                                                                     : woken[gi];
            end else begin : g_top
                // The top slot always empties when anything issues.
                assign shifted[gi] = fire ? '0 : woken[gi];
            end
        end
    endgenerate

    rs_pick_oldest #(.DEPTH(DEPTH)) u_pick (
        .req   (ready_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    assign iss_valid   = sel_found;
    assign iss_op      = sel_found ? entries_q[sel_idx].op       : '0;
    assign iss_a       = sel_found ? entries_q[sel_idx].src1.val : '0;
    assign iss_b       = sel_found ? entries_q[sel_idx].src2.val : '0;
    assign iss_rob_tag = sel_found ? entries_q[sel_idx].rob_tag  : '0;

    assign disp_ready = (count_q != CW'(DEPTH));
    assign accept     = disp_valid && disp_ready && (disp_station == STATION_ID);
    assign fire       = sel_found && iss_ready;
    // After compaction the free slot is one lower if something issued.
    assign wr_idx     = fire ? (count_q - CW'(1)) : count_q;
    assign count      = count_q;

    always_comb begin
        disp_raw          = '0;
        disp_raw.valid    = 1'b1;
        disp_raw.op       = disp_op;
        disp_raw.rob_tag  = disp_rob_tag;
        disp_raw.src1.val = disp_src1_val;
        disp_raw.src1.rdy = disp_src1_rdy;
        disp_raw.src1.tag = disp_src1_tag;
        if (disp_use_imm) begin
            disp_raw.src2.val = disp_imm;
            disp_raw.src2.rdy = 1'b1;
            disp_raw.src2.tag = '0;
        end else begin
            disp_raw.src2.val = disp_src2_val;
            disp_raw.src2.rdy = disp_src2_rdy;
            disp_raw.src2.tag = disp_src2_tag;
        end
    end

    // Same-cycle CDB bypass for the incoming instruction.
    assign disp_entry = rs_wake(disp_raw, cdb_valid, cdb_tag, cdb_data);

    always_comb begin
        entries_d = shifted;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (CW'(i) == wr_idx)) begin
                entries_d[i] = disp_entry;
            end
        end
        count_d = count_q + CW'(accept) - CW'(fire);
        if (flush) begin
            entries_d = '{default: '0};
            count_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries_q <= '{default: '0};
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

endmodule
